bcd_serial_addsub: RTL and testbench
====================================

// Module: bcd_serial_addsub
// PURPOSE
//  Multi-digit BCD add/subtract sequencer built around one shared single-digit BCD adder.
//  - Latches two DIGITS-wide packed-BCD operands on a start handshake.
//  - Feeds the adder one digit per cycle, LSD first, with a registered decimal carry between digits.
//  - Reports result, carry/borrow and a bad-digit flag with a one-cycle done pulse.
//  - Serves as the arithmetic engine behind the lab's calculator/front-panel control logic.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1); all BCD buses are 4*DIGITS bits wide
// PORTS
//  clk     in   1         rising-edge clock
//  rst_n   in   1         asynchronous, active-low reset
//  start   in   1         request; accepted only on a clk edge where ready=1
//  sub     in   1         0: a+b, 1: a-b; sampled with start
//  a       in   4*DIGITS  packed BCD operand, digit 0 = a[3:0]; sampled with start
//  b       in   4*DIGITS  packed BCD operand; sampled with start
//  ready   out  1         1 iff FSM is in IDLE
//  done    out  1         one-cycle pulse; result/cout/err are valid from this cycle on
//  result  out  4*DIGITS  packed BCD result, held until the next accepted start
//  cout    out  1         add: decimal carry out of MSD; sub: 1 = no borrow (a>=b)
//  err     out  1         1 if any digit of a or b was >9 during the last operation
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ready=1, done=0, result=0, cout=0, err=0, digit index=0, carry=0.
//  FSM states and transitions:
//   - IDLE -> RUN on start&ready.
//     - Latch a, b, sub.
//     - Clear result, err and index.
//     - Carry register := sub (ten's-complement +1).
//   - RUN: each cycle processes digit idx.
//     - b_eff = sub ? 9-b[idx] : b[idx].
//     - {carry, result[idx]} := bcd_add(a[idx], b_eff, carry).
//     - err |= (a[idx]>9) | (b[idx]>9).
//     - idx++.
//     - On idx==DIGITS-1: go to DONE, cout := final carry, done := 1.
//   - DONE: one cycle, done=1, ready=0; then go to IDLE and done := 0.
//  Latency:
//   - done rises on the DIGITS-th rising edge after the start-sampling edge.
//   - ready returns 1 edge later, so back-to-back throughput is DIGITS+2 cycles.
//  Subtract result:
//   - a<b gives the ten's complement mod 10^DIGITS with cout=0.
//   - Example: 1234-5000 = 6234, cout=0.
//   - No sign/magnitude conversion is done here.
//  Width rule: bcd_add output is a 4-bit digit plus 1 carry; a carry out of the MSD never enters result.
//  Bad digits (>9):
//   - Affected result digits are unspecified.
//   - err=1 at done; no abort; the sequence still runs to completion.
//  Boundary conditions:
//   - start while ready=0 (RUN/DONE): ignored, not queued; a/b/sub changes are ignored.
//   - start held high continuously: a new op is accepted each time the FSM is in IDLE.
//   - DIGITS=1: RUN lasts exactly one cycle.
//   - rst_n asserted mid-RUN: immediate abort to reset values; no done pulse.
//   - result/cout/err persist through IDLE until the next accepted start.
// STRUCTURE
//  Package bcd_pkg:
//   - typedef logic [3:0] bcd_digit_t
//   - enum state_t {IDLE, RUN, DONE}
//   - localparam BCD_MAX = 4'd9
//   - function nines_comp(bcd_digit_t)
//  One sub-module instance: the existing combinational bcd_full_adder (digit adder).
//  Index counter width: $clog2(DIGITS) with minimum 1.
//  Operand digit select: indexed part-select [idx*4 +: 4] on the latched registers.
// TESTING (DIGITS=4 unless noted)
//  1. add 1234+5678 -> result=6912, cout=0, err=0; done on 4th edge after start; ready=0 until the edge after done.
//  2. add 9999+0001 -> result=0000, cout=1 (full carry ripple); 0950+0050 -> 1000, cout=0.
//  3. sub 5000-1234 -> 3766, cout=1; sub 1234-5000 -> 6234, cout=0; sub 0000-0000 -> 0000, cout=1.
//  4. start pulsed mid-RUN with new a/b -> ignored, first result intact; start held high -> back-to-back ops every 6 cycles.
//  5. rst_n low in 2nd RUN cycle -> all outputs at reset values at once, no done; next op 0001+0001 -> 0002.
//  6. a=12A4 (digit 0xA) + 0000 -> err=1 at done; following clean op -> err=0; repeat tests 1-3 with DIGITS=1 and DIGITS=8.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial BCD add/subtract engine.
//   bcd_digit_t : one packed BCD digit
//   state_t     : sequencer states
//   BCD_MAX     : largest legal BCD digit value
//   nines_comp  : nine's complement of a digit (used to turn a-b into a+(9..9-b)+1)
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Illegal digits (>9) wrap here; their result digits are don't-care anyway.
   function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Request/response bundle of the serial BCD add/subtract engine.
//   start, sub, a, b              : request side (driven by master)
//   ready, done, result, cout, err : response side (driven by slave)
interface bcd_serial_addsub_if #(
   parameter int DIGITS = 4
);

   logic                  start;
   logic                  sub;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  ready;
   logic                  done;
   logic [4*DIGITS-1:0]   result;
   logic                  cout;
   logic                  err;

   modport master (
      output start, sub, a, b,
      input  ready, done, result, cout, err
   );

   modport slave (
      input  start, sub, a, b,
      output ready, done, result, cout, err
   );

endinterface

// File: rtl/bcd_full_adder.sv
// Combinational single-digit BCD adder.
//   a_i, b_i : BCD digits
//   c_i      : decimal carry in
//   sum_o    : BCD sum digit
//   c_o      : decimal carry out
module bcd_full_adder
   import bcd_pkg::*;
(
   input  bcd_digit_t a_i,
   input  bcd_digit_t b_i,
   input  logic       c_i,
   output bcd_digit_t sum_o,
   output logic       c_o
);

   logic [4:0] bin_sum;

   always_comb begin
      bin_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
      c_o     = (bin_sum > {1'b0, BCD_MAX});
      // +6 skips the six unused codes; the mod-16 wrap drops the tens digit.
      sum_o   = c_o ? (bin_sum[3:0] + 4'd6) : bin_sum[3:0];
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD add/subtract sequencer using one shared digit adder,
// one digit per cycle, least significant digit first.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bcd_serial_addsub_if (start/sub/a/b in,
//            ready/done/result/cout/err out)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready=1, waiting for start; last result/cout/err held
//   RUN   | processing digit idx_q, carry chained through carry_q
//   DONE  | one-cycle done pulse, ready=0
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   bcd_serial_addsub_if.slave  bus
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SEL_W = $clog2(W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic             sub_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [W-1:0]     result_q;
   logic             cout_q;
   logic             err_q;
   logic             done_q;

   logic [SEL_W-1:0] base_d;
   bcd_digit_t       a_dig_d;
   bcd_digit_t       b_dig_d;
   bcd_digit_t       b_eff_d;
   bcd_digit_t       sum_d;
   logic             carry_d;
   logic             bad_d;

   always_comb begin
      base_d  = SEL_W'({idx_q, 2'b00});
      a_dig_d = a_q[base_d +: 4];
      b_dig_d = b_q[base_d +: 4];
      // Subtraction is a + nines(b) + 1, the +1 being the preset carry.
      b_eff_d = sub_q ? nines_comp(b_dig_d) : b_dig_d;
      bad_d   = (a_dig_d > BCD_MAX) | (b_dig_d > BCD_MAX);
   end

   bcd_full_adder u_digit_adder (
      .a_i   (a_dig_d),
      .b_i   (b_eff_d),
      .c_i   (carry_q),
      .sum_o (sum_d),
      .c_o   (carry_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  sub_q    <= bus.sub;
                  carry_q  <= bus.sub;
                  result_q <= '0;
                  err_q    <= 1'b0;
                  idx_q    <= '0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               result_q[base_d +: 4] <= sum_d;
               carry_q               <= carry_d;
               err_q                 <= err_q | bad_d;
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  cout_q  <= carry_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready  = (state_q == IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   bcd_serial_addsub_if #(.DIGITS(1)) bus1 ();
   bcd_serial_addsub_if #(.DIGITS(4)) bus4 ();
   bcd_serial_addsub_if #(.DIGITS(8)) bus8 ();

   bcd_serial_addsub #(.DIGITS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   bcd_serial_addsub #(.DIGITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   bcd_serial_addsub #(.DIGITS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model (decimal arithmetic) ----------------
   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic longint bcd2int(input logic [31:0] v, input int nd);
      longint x = 0;
      for (int i = nd - 1; i >= 0; i--) x = x * 10 + longint'(v[i*4 +: 4]);
      return x;
   endfunction

   function automatic logic [31:0] int2bcd(input longint x, input int nd);
      logic [31:0] r = '0;
      longint t = x;
      for (int i = 0; i < nd; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic has_bad(input logic [31:0] v, input int nd);
      logic bad = 1'b0;
      for (int i = 0; i < nd; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   task automatic model(input int nd, input logic s, input logic [31:0] av, bv,
                        output logic [31:0] r, output logic co);
      longint m, x, y, t;
      m = pow10(nd);
      x = bcd2int(av, nd);
      y = bcd2int(bv, nd);
      if (s) begin
         t  = x - y + m;
         co = (x >= y);
      end else begin
         t  = x + y;
         co = (t >= m);
      end
      r = int2bcd(t % m, nd);
   endtask

   function automatic logic [31:0] rand_bcd(input int nd);
      logic [31:0] r = '0;
      for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'($urandom_range(9));
      return r;
   endfunction

   // ---------------- DUT access ----------------
   task automatic set_in(input int nd, input logic st, input logic s, input logic [31:0] av, bv);
      case (nd)
         1: begin bus1.start = st; bus1.sub = s; bus1.a = av[3:0];  bus1.b = bv[3:0];  end
         8: begin bus8.start = st; bus8.sub = s; bus8.a = av;       bus8.b = bv;       end
         default: begin bus4.start = st; bus4.sub = s; bus4.a = av[15:0]; bus4.b = bv[15:0]; end
      endcase
   endtask

   task automatic get_out(input int nd, output logic rdy, dn, output logic [31:0] r,
                          output logic co, e);
      case (nd)
         1: begin rdy = bus1.ready; dn = bus1.done; r = {28'b0, bus1.result}; co = bus1.cout; e = bus1.err; end
         8: begin rdy = bus8.ready; dn = bus8.done; r = bus8.result; co = bus8.cout; e = bus8.err; end
         default: begin rdy = bus4.ready; dn = bus4.done; r = {16'b0, bus4.result}; co = bus4.cout; e = bus4.err; end
      endcase
   endtask

   // One operation: lat = edges from the accepting edge to the first done sample
   // (-1 on timeout); hs_bad flags ready=1 while busy or ready=0 the edge after done.
   task automatic drive(input int nd, input logic s, input logic [31:0] av, bv,
                        output int lat, output logic [31:0] r, output logic co, e,
                        output logic hs_bad);
      logic rdy, dn, cc, ee;
      logic [31:0] rr;
      lat = -1; r = '0; co = 1'b0; e = 1'b0; hs_bad = 1'b0;
      set_in(nd, 1'b1, s, av, bv);
      @(posedge clk); #1;
      set_in(nd, 1'b0, s, av, bv);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         get_out(nd, rdy, dn, rr, cc, ee);
         if (rdy) hs_bad = 1'b1;
         if (dn) begin
            lat = i; r = rr; co = cc; e = ee;
            break;
         end
      end
      @(posedge clk); #1;
      get_out(nd, rdy, dn, rr, cc, ee);
      if (!rdy || dn) hs_bad = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic rdy, dn, co, e;
      logic [31:0] r;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      get_out(4, rdy, dn, r, co, e);
      n_total++; if (rdy !== 1'b1) $display("FAIL reset ready: got %b expected 1", rdy); else n_pass++;
      n_total++; if (dn !== 1'b0) $display("FAIL reset done: got %b expected 0", dn); else n_pass++;
      n_total++; if (r !== 32'h0) $display("FAIL reset result: got %h expected 0", r); else n_pass++;
      n_total++; if ({co, e} !== 2'b00) $display("FAIL reset cout/err: got %b%b expected 00", co, e); else n_pass++;
      get_out(1, rdy, dn, r, co, e);
      n_total++; if ({rdy, dn} !== 2'b10) $display("FAIL reset d1 ready/done: got %b%b expected 10", rdy, dn); else n_pass++;
      get_out(8, rdy, dn, r, co, e);
      n_total++; if ({rdy, dn} !== 2'b10) $display("FAIL reset d8 ready/done: got %b%b expected 10", rdy, dn); else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_arith(input int nd);
      logic [31:0] va[$];
      logic [31:0] vb[$];
      logic        vs[$];
      logic [31:0] r, er;
      logic        co, eco, e, hs;
      int          lat;
      case (nd)
         1: begin
            vs = '{0, 0, 0, 1, 1, 1};
            va = '{32'h9, 32'h4, 32'h0, 32'h3, 32'h7, 32'h0};
            vb = '{32'h1, 32'h5, 32'h0, 32'h7, 32'h3, 32'h0};
         end
         8: begin
            vs = '{0, 0, 1, 1, 1};
            va = '{32'h99999999, 32'h12345678, 32'h12345678, 32'h00000000, 32'h50000000};
            vb = '{32'h00000001, 32'h87654321, 32'h87654321, 32'h00000000, 32'h00000001};
         end
         default: begin
            vs = '{0, 0, 0, 1, 1, 1};
            va = '{32'h1234, 32'h9999, 32'h0950, 32'h5000, 32'h1234, 32'h0000};
            vb = '{32'h5678, 32'h0001, 32'h0050, 32'h1234, 32'h5000, 32'h0000};
         end
      endcase
      for (int i = 0; i < 12; i++) begin
         vs.push_back(1'($urandom_range(1)));
         va.push_back(rand_bcd(nd));
         vb.push_back(rand_bcd(nd));
      end
      foreach (va[k]) begin
         drive(nd, vs[k], va[k], vb[k], lat, r, co, e, hs);
         model(nd, vs[k], va[k], vb[k], er, eco);
         n_total++; if (r !== er)
            $display("FAIL arith d%0d result %h %s %h: got %h expected %h", nd, va[k], vs[k] ? "-" : "+", vb[k], r, er);
         else n_pass++;
         n_total++; if (co !== eco)
            $display("FAIL arith d%0d cout %h %s %h: got %b expected %b", nd, va[k], vs[k] ? "-" : "+", vb[k], co, eco);
         else n_pass++;
         n_total++; if (e !== 1'b0) $display("FAIL arith d%0d err: got %b expected 0", nd, e); else n_pass++;
         n_total++; if (lat !== nd) $display("FAIL arith d%0d latency: got %0d expected %0d", nd, lat, nd); else n_pass++;
         n_total++; if (hs !== 1'b0) $display("FAIL arith d%0d ready handshake: got bad=%b expected 0", nd, hs); else n_pass++;
      end
   endtask

   task automatic test_ignore_start();
      logic rdy, dn, co, e;
      logic [31:0] r, rr;
      int lat;
      set_in(4, 1'b1, 1'b0, 32'h1234, 32'h5678);
      @(posedge clk); #1;
      set_in(4, 1'b0, 1'b0, 32'h1234, 32'h5678);
      @(posedge clk); #1;
      set_in(4, 1'b1, 1'b1, 32'h9999, 32'h9999);
      @(posedge clk); #1;
      set_in(4, 1'b0, 1'b1, 32'h9999, 32'h9999);
      lat = -1; rr = '0;
      for (int i = 3; i <= 20; i++) begin
         @(posedge clk); #1;
         get_out(4, rdy, dn, r, co, e);
         if (dn) begin lat = i; rr = r; break; end
      end
      n_total++; if (lat !== 4) $display("FAIL ignore_start latency: got %0d expected 4", lat); else n_pass++;
      n_total++; if (rr !== 32'h6912) $display("FAIL ignore_start result: got %h expected 6912", rr); else n_pass++;
      repeat (4) @(posedge clk);
      #1;
      get_out(4, rdy, dn, r, co, e);
      n_total++; if ({rdy, dn} !== 2'b10) $display("FAIL ignore_start no queued op: got ready/done %b%b expected 10", rdy, dn); else n_pass++;
      n_total++; if (r !== 32'h6912) $display("FAIL ignore_start result held: got %h expected 6912", r); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic rdy, dn, co, e;
      logic [31:0] r;
      int done_at[$];
      logic [31:0] res_at[$];
      int waited;
      set_in(4, 1'b1, 1'b0, 32'h0123, 32'h0456);
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         get_out(4, rdy, dn, r, co, e);
         if (dn) begin done_at.push_back(i); res_at.push_back(r); end
      end
      set_in(4, 1'b0, 1'b0, 32'h0123, 32'h0456);
      n_total++; if (done_at.size() !== 5) $display("FAIL b2b pulse count: got %0d expected 5", done_at.size()); else n_pass++;
      if (done_at.size() > 0) begin
         n_total++; if (done_at[0] !== 5) $display("FAIL b2b first done: got %0d expected 5", done_at[0]); else n_pass++;
      end
      for (int k = 1; k < done_at.size(); k++) begin
         n_total++; if (done_at[k] - done_at[k-1] !== 6)
            $display("FAIL b2b spacing %0d: got %0d expected 6", k, done_at[k] - done_at[k-1]);
         else n_pass++;
      end
      foreach (res_at[k]) begin
         n_total++; if (res_at[k] !== 32'h0579) $display("FAIL b2b result %0d: got %h expected 0579", k, res_at[k]); else n_pass++;
      end
      waited = 0;
      get_out(4, rdy, dn, r, co, e);
      while (!rdy && waited < 20) begin
         @(posedge clk); #1;
         get_out(4, rdy, dn, r, co, e);
         waited++;
      end
      n_total++; if (rdy !== 1'b1) $display("FAIL b2b return to idle: got ready %b expected 1", rdy); else n_pass++;
   endtask

   task automatic test_reset_midrun();
      logic rdy, dn, co, e, hs;
      logic [31:0] r;
      logic saw_done;
      int lat;
      drive(4, 1'b0, 32'h9999, 32'h0001, lat, r, co, e, hs);
      n_total++; if ({r, co} !== {32'h0000, 1'b1}) $display("FAIL midrun setup carry: got %h/%b expected 0000/1", r, co); else n_pass++;
      set_in(4, 1'b1, 1'b0, 32'h111A, 32'h2222);
      @(posedge clk); #1;
      set_in(4, 1'b0, 1'b0, 32'h111A, 32'h2222);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      get_out(4, rdy, dn, r, co, e);
      n_total++; if ({rdy, dn} !== 2'b10) $display("FAIL midrun reset ready/done: got %b%b expected 10", rdy, dn); else n_pass++;
      n_total++; if (r !== 32'h0) $display("FAIL midrun reset result: got %h expected 0", r); else n_pass++;
      n_total++; if ({co, e} !== 2'b00) $display("FAIL midrun reset cout/err: got %b%b expected 00", co, e); else n_pass++;
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         get_out(4, rdy, dn, r, co, e);
         if (dn) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         get_out(4, rdy, dn, r, co, e);
         if (dn) saw_done = 1'b1;
      end
      n_total++; if (saw_done !== 1'b0) $display("FAIL midrun no done: got done pulse expected none"); else n_pass++;
      drive(4, 1'b0, 32'h0001, 32'h0001, lat, r, co, e, hs);
      n_total++; if (r !== 32'h0002) $display("FAIL midrun next op: got %h expected 0002", r); else n_pass++;
      n_total++; if (lat !== 4) $display("FAIL midrun next latency: got %0d expected 4", lat); else n_pass++;
   endtask

   task automatic test_err();
      logic [31:0] va[$];
      logic [31:0] vb[$];
      logic        vs[$];
      logic [31:0] r, er;
      logic        co, eco, e, hs;
      int          lat;
      vs = '{0, 1, 0, 0, 1};
      va = '{32'h12A4, 32'h0000, 32'h0001, 32'hF999, 32'h4321};
      vb = '{32'h0000, 32'hB000, 32'h0002, 32'h0000, 32'h1234};
      foreach (va[k]) begin
         drive(4, vs[k], va[k], vb[k], lat, r, co, e, hs);
         n_total++; if (e !== (has_bad(va[k], 4) | has_bad(vb[k], 4)))
            $display("FAIL err flag %h/%h: got %b expected %b", va[k], vb[k], e, has_bad(va[k], 4) | has_bad(vb[k], 4));
         else n_pass++;
         n_total++; if (lat !== 4) $display("FAIL err latency %h/%h: got %0d expected 4", va[k], vb[k], lat); else n_pass++;
         if (!has_bad(va[k], 4) && !has_bad(vb[k], 4)) begin
            model(4, vs[k], va[k], vb[k], er, eco);
            n_total++; if ({r, co} !== {er, eco})
               $display("FAIL err clean op %h/%h: got %h/%b expected %h/%b", va[k], vb[k], r, co, er, eco);
            else n_pass++;
         end
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      set_in(1, 1'b0, 1'b0, '0, '0);
      set_in(4, 1'b0, 1'b0, '0, '0);
      set_in(8, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_arith(4);
      test_ignore_start();
      test_back_to_back();
      test_reset_midrun();
      test_err();
      test_arith(1);
      test_arith(8);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
